// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: drives PC and
// pipeline-register enables/flushes for load-use, LSU wait, redirect and trap.
module pipe_ctrl #(
    parameter int REG_AW       = 5,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1_idx,
    input  logic [REG_AW-1:0] id_rs2_idx,
    input  logic              id_rs1_ren,
    input  logic              id_rs2_ren,
    input  logic [REG_AW-1:0] ex_rd_idx,
    input  logic              ex_is_load,
    input  logic              ex_redirect,
    input  logic              lsu_req,
    input  logic              lsu_resp,
    input  logic              trap_req,
    output logic              pc_wen,
    output logic              pc_sel_trap,
    output logic              if_id_wen,
    output logic              id_ex_wen,
    output logic              ex_mem_wen,
    output logic              mem_wb_wen,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mem_wb_flush,
    output logic              lsu_kill,
    output logic [1:0]        ctrl_state,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_DRAIN    = 2'd2;
    localparam int         DW          = 4;

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [DW-1:0]    drain_r;
    logic [DW-1:0]    drain_nx_s;
    logic [CNT_W-1:0] stall_r;
    logic             lsu_wait_s;
    logic             load_use_s;

    logic pc_wen_s, pc_sel_trap_s, lsu_kill_s;
    logic if_id_wen_s, id_ex_wen_s, ex_mem_wen_s, mem_wb_wen_s;
    logic if_id_flush_s, id_ex_flush_s, ex_mem_flush_s, mem_wb_flush_s;

    // Hazard detection terms
    always_comb begin
        lsu_wait_s = ((state_r == ST_MEM_WAIT) && !lsu_resp) ||
                     ((state_r == ST_RUN) && lsu_req && !lsu_resp);
        load_use_s = ex_is_load && (ex_rd_idx != {REG_AW{1'b0}}) &&
                     ((id_rs1_ren && (id_rs1_idx == ex_rd_idx)) ||
                      (id_rs2_ren && (id_rs2_idx == ex_rd_idx)));
    end

    // Prioritised control outputs and next-state selection
    always_comb begin
        pc_wen_s       = 1'b1;
        pc_sel_trap_s  = 1'b0;
        lsu_kill_s     = 1'b0;
        if_id_wen_s    = 1'b1;
        id_ex_wen_s    = 1'b1;
        ex_mem_wen_s   = 1'b1;
        mem_wb_wen_s   = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        ex_mem_flush_s = 1'b0;
        mem_wb_flush_s = 1'b0;
        state_nx_s     = state_r;
        drain_nx_s     = drain_r;
        if (rst) begin
            pc_wen_s       = 1'b0;
            if_id_wen_s    = 1'b0;
            id_ex_wen_s    = 1'b0;
            ex_mem_wen_s   = 1'b0;
            mem_wb_wen_s   = 1'b0;
            if_id_flush_s  = 1'b1;
            id_ex_flush_s  = 1'b1;
            ex_mem_flush_s = 1'b1;
            mem_wb_flush_s = 1'b1;
        end else if (trap_req) begin
            pc_sel_trap_s  = 1'b1;
            if_id_flush_s  = 1'b1;
            id_ex_flush_s  = 1'b1;
            ex_mem_flush_s = 1'b1;
            mem_wb_flush_s = 1'b1;
            lsu_kill_s     = (state_r == ST_MEM_WAIT);
            state_nx_s     = ST_DRAIN;
            drain_nx_s     = DW'(DRAIN_CYCLES);
        end else if (lsu_wait_s) begin
            pc_wen_s       = 1'b0;
            if_id_wen_s    = 1'b0;
            id_ex_wen_s    = 1'b0;
            ex_mem_wen_s   = 1'b0;
            mem_wb_flush_s = 1'b1;
            state_nx_s     = ST_MEM_WAIT;
        end else if (state_r == ST_DRAIN) begin
            if_id_flush_s = 1'b1;
            if (drain_r <= 4'd1) begin
                state_nx_s = ST_RUN;
                drain_nx_s = 4'd0;
            end else begin
                drain_nx_s = drain_r - 4'd1;
            end
        end else begin
            // RUN, the MEM_WAIT response cycle, and recovery from the unused encoding
            state_nx_s = ST_RUN;
            if (ex_redirect) begin
                if_id_flush_s = 1'b1;
                id_ex_flush_s = 1'b1;
            end else if (load_use_s) begin
                pc_wen_s      = 1'b0;
                if_id_wen_s   = 1'b0;
                id_ex_flush_s = 1'b1;
            end else begin
                pc_wen_s = 1'b1;
            end
        end
    end

    // State, drain countdown and saturating stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
            drain_r <= 4'd0;
            stall_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            drain_r <= drain_nx_s;
            if (!pc_wen_s && (stall_r != {CNT_W{1'b1}})) begin
                stall_r <= stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign pc_wen       = pc_wen_s;
    assign pc_sel_trap  = pc_sel_trap_s;
    assign lsu_kill     = lsu_kill_s;
    assign if_id_wen    = if_id_wen_s;
    assign id_ex_wen    = id_ex_wen_s;
    assign ex_mem_wen   = ex_mem_wen_s;
    assign mem_wb_wen   = mem_wb_wen_s;
    assign if_id_flush  = if_id_flush_s;
    assign id_ex_flush  = id_ex_flush_s;
    assign ex_mem_flush = ex_mem_flush_s;
    assign mem_wb_flush = mem_wb_flush_s;
    assign ctrl_state   = state_r;
    assign stall_cycles = stall_r;

endmodule
